// File: rtl/line_sensor_filter_pkg.sv
// Shared constants and types for the line sensor filter.
package line_sensor_filter_pkg;

    localparam int ADC_W  = 12;
    localparam int NUM_CH = 3;

    // LINE_BITS is {CH1, CH2, CH3}; bit index of each channel.
    localparam int CH1_BIT = 2;
    localparam int CH2_BIT = 1;
    localparam int CH3_BIT = 0;

    localparam logic [NUM_CH-1:0] LINE_ALL_BLACK = 3'b111;
    localparam logic [NUM_CH-1:0] LINE_ALL_WHITE = 3'b000;

    typedef enum logic [1:0] {
        ST_FOLLOW    = 2'd0,
        ST_NODE_SEEN = 2'd1,
        ST_LOST      = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/line_sensor_filter_avg.sv
// One sensor channel: block accumulator, averaged value and hysteresis bit.
module sensor_avg_hyst
    import line_sensor_filter_pkg::*;
#(
    parameter int               AVG_LOG2 = 4,
    parameter logic [ADC_W-1:0] TH_HI    = 12'd2000,
    parameter logic [ADC_W-1:0] TH_LO    = 12'd1600
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             tick,
    input  logic             last,
    input  logic [ADC_W-1:0] adc_data,
    output logic [ADC_W-1:0] avg,
    output logic             line_bit
);

    // Wide enough for 2**AVG_LOG2 full-scale samples, so the sum never wraps.
    localparam int ACC_W = ADC_W + AVG_LOG2;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [ADC_W-1:0] avg_nxt;
    logic             bit_nxt;

    // Running sum including the sample presented this tick; truncating divide.
    always_comb begin
        sum     = acc + ACC_W'(adc_data);
        avg_nxt = sum[ACC_W-1:AVG_LOG2];
    end

    // Hysteresis on the new average; inside the band the previous bit holds.
    always_comb begin
        bit_nxt = line_bit;
        if (avg_nxt >= TH_HI)
            bit_nxt = 1'b1;
        else if (avg_nxt <= TH_LO)
            bit_nxt = 1'b0;
    end

    // Accumulate on every tick; on the last sample publish and restart the block.
    always_ff @(posedge sclk) begin
        if (rst) begin
            acc      <= '0;
            avg      <= '0;
            line_bit <= 1'b0;
        end else if (tick) begin
            if (last) begin
                acc      <= '0;
                avg      <= avg_nxt;
                line_bit <= bit_nxt;
            end else begin
                acc <= sum;
            end
        end
    end

endmodule

// File: rtl/line_sensor_filter.sv
// Line sensor filter: sample divider, 3 averaging/hysteresis channels,
// node / line-loss confirmation FSM.
module line_sensor_filter
    import line_sensor_filter_pkg::*;
#(
    parameter int               SAMPLE_DIV   = 48,
    parameter int               AVG_LOG2     = 4,
    parameter logic [ADC_W-1:0] TH_HI        = 12'd2000,
    parameter logic [ADC_W-1:0] TH_LO        = 12'd1600,
    parameter int               NODE_CONFIRM = 3
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic [ADC_W-1:0]  ADC_DATA_CH1,
    input  logic [ADC_W-1:0]  ADC_DATA_CH2,
    input  logic [ADC_W-1:0]  ADC_DATA_CH3,
    output logic [ADC_W-1:0]  AVG_CH1,
    output logic [ADC_W-1:0]  AVG_CH2,
    output logic [ADC_W-1:0]  AVG_CH3,
    output logic              AVG_VALID,
    output logic [NUM_CH-1:0] LINE_BITS,
    output logic              NODE_PULSE,
    output logic [7:0]        NODE_COUNT,
    output logic              LINE_LOST
);

    if (TH_LO >= TH_HI) begin : g_th_check
        $error("line_sensor_filter: TH_LO must be below TH_HI");
    end

    localparam int DIV_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W      = $clog2(NODE_CONFIRM + 1);
    localparam int VLD_STAGES = 0;
    localparam logic [CNT_W-1:0] CONFIRM = CNT_W'(NODE_CONFIRM);

    logic [DIV_W-1:0]              div_cnt;
    logic [AVG_LOG2-1:0]           smp_cnt;
    logic                          tick;
    logic                          last;
    logic                          final_tick;
    logic [VLD_STAGES:0]           vld_pipe;

    logic [NUM_CH-1:0][ADC_W-1:0]  adc_data;
    logic [NUM_CH-1:0][ADC_W-1:0]  avg;
    logic [NUM_CH-1:0]             line_bits;

    fsm_state_e                    state, state_nxt;
    logic [CNT_W-1:0]              blk_cnt, blk_nxt;
    logic [CNT_W-1:0]              wht_cnt, wht_nxt;
    logic                          node_pulse;
    logic [7:0]                    node_count;

    assign tick       = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign last       = &smp_cnt;
    assign final_tick = tick & last;
    assign adc_data   = {ADC_DATA_CH1, ADC_DATA_CH2, ADC_DATA_CH3};

    // Sample divider: free-running 0..SAMPLE_DIV-1.
    always_ff @(posedge sclk) begin
        if (rst)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DIV_W'(1);
    end

    // Samples taken in the current block; all-ones marks the block's last sample.
    always_ff @(posedge sclk) begin
        if (rst)
            smp_cnt <= '0;
        else if (tick)
            smp_cnt <= smp_cnt + AVG_LOG2'(1);
    end

    // AVG_VALID trails the final tick by one cycle, aligned with the new averages.
    always_ff @(posedge sclk) begin
        if (rst)
            vld_pipe <= '0;
        else
            vld_pipe[0] <= final_tick;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sensor_avg_hyst #(
            .AVG_LOG2 (AVG_LOG2),
            .TH_HI    (TH_HI),
            .TH_LO    (TH_LO)
        ) u_ch (
            .sclk     (sclk),
            .rst      (rst),
            .tick     (tick),
            .last     (last),
            .adc_data (adc_data[i]),
            .avg      (avg[i]),
            .line_bit (line_bits[i])
        );
    end

    // FSM state, confirm counters and registered node pulse / count.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state      <= ST_FOLLOW;
            blk_cnt    <= '0;
            wht_cnt    <= '0;
            node_pulse <= 1'b0;
            node_count <= '0;
        end else begin
            state      <= state_nxt;
            blk_cnt    <= blk_nxt;
            wht_cnt    <= wht_nxt;
            node_pulse <= (state == ST_FOLLOW) && (state_nxt == ST_NODE_SEEN);
            if ((state == ST_FOLLOW) && (state_nxt == ST_NODE_SEEN))
                node_count <= node_count + 8'd1;
        end
    end

    // Next state: only evaluated on a fresh average, using the just-updated bits.
    always_comb begin
        state_nxt = state;
        blk_nxt   = blk_cnt;
        wht_nxt   = wht_cnt;
        if (vld_pipe[0]) begin
            if (line_bits == LINE_ALL_BLACK)
                blk_nxt = (blk_cnt == CONFIRM) ? CONFIRM : blk_cnt + CNT_W'(1);
            else
                blk_nxt = '0;
            if (line_bits == LINE_ALL_WHITE)
                wht_nxt = (wht_cnt == CONFIRM) ? CONFIRM : wht_cnt + CNT_W'(1);
            else
                wht_nxt = '0;

            case (state)
                ST_FOLLOW: begin
                    if (blk_nxt == CONFIRM)
                        state_nxt = ST_NODE_SEEN;
                    else if (wht_nxt == CONFIRM)
                        state_nxt = ST_LOST;
                end
                ST_NODE_SEEN: begin
                    if (line_bits != LINE_ALL_BLACK)
                        state_nxt = ST_FOLLOW;
                end
                ST_LOST: begin
                    if (line_bits != LINE_ALL_WHITE)
                        state_nxt = ST_FOLLOW;
                end
                default: state_nxt = ST_FOLLOW;
            endcase
        end
    end

    // Output decode.
    always_comb begin
        AVG_CH1    = avg[CH1_BIT];
        AVG_CH2    = avg[CH2_BIT];
        AVG_CH3    = avg[CH3_BIT];
        AVG_VALID  = vld_pipe[0];
        LINE_BITS  = line_bits;
        NODE_PULSE = node_pulse;
        NODE_COUNT = node_count;
        LINE_LOST  = (state == ST_LOST);
    end

endmodule

// File: tb/tb_line_sensor_filter.sv
// Randomised scoreboard bench for line_sensor_filter (SAMPLE_DIV shortened to 4).
module tb_line_sensor_filter;

    localparam int SAMPLE_DIV = 4;
    localparam int NWIN       = 16;
    localparam int NC         = 3;
    localparam int TH_HI      = 2000;
    localparam int TH_LO      = 1600;

    logic        sclk = 1'b0;
    logic        rst  = 1'b1;
    logic [11:0] ch1 = '0, ch2 = '0, ch3 = '0;
    logic [11:0] AVG_CH1, AVG_CH2, AVG_CH3;
    logic        AVG_VALID;
    logic [2:0]  LINE_BITS;
    logic        NODE_PULSE;
    logic [7:0]  NODE_COUNT;
    logic        LINE_LOST;

    line_sensor_filter #(.SAMPLE_DIV(SAMPLE_DIV)) dut (
        .sclk         (sclk),
        .rst          (rst),
        .ADC_DATA_CH1 (ch1),
        .ADC_DATA_CH2 (ch2),
        .ADC_DATA_CH3 (ch3),
        .AVG_CH1      (AVG_CH1),
        .AVG_CH2      (AVG_CH2),
        .AVG_CH3      (AVG_CH3),
        .AVG_VALID    (AVG_VALID),
        .LINE_BITS    (LINE_BITS),
        .NODE_PULSE   (NODE_PULSE),
        .NODE_COUNT   (NODE_COUNT),
        .LINE_LOST    (LINE_LOST)
    );

    always #5 sclk = ~sclk;

    int pcnt = 0;
    always @(posedge sclk) pcnt <= pcnt + 1;

    int npass  = 0;
    int ntotal = 0;

    task automatic chk(input string nm, input int act, input int req);
        ntotal++;
        if (act == req) npass++;
        else $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, req, $time);
    endtask

    typedef struct {
        int a1, a2, a3;
        int bits;
        int np;
        int cnt;
        int lost;
        int cyc;
    } exp_t;

    exp_t sb[$];

    // ---------------- reference model ----------------
    int m_sum[3];
    int m_n;
    int m_bit[3];
    int hist[$];      // history of 3-bit line codes, one per completed average
    int mode;         // 0 following, 1 sitting on a node, 2 line lost
    int m_cnt;

    function automatic int run_len(input int code);
        int r = 0;
        for (int k = hist.size() - 1; k >= 0; k--) begin
            if (hist[k] != code) break;
            r++;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin m_sum[i] = 0; m_bit[i] = 0; end
        m_n   = 0;
        hist.delete();
        mode  = 0;
        m_cnt = 0;
    endtask

    // Present one sample for one tick period; record the expected outcome on block end.
    task automatic sample(input int a, input int b, input int c);
        int v[3];
        int av[3];
        exp_t e;
        v[0] = a; v[1] = b; v[2] = c;
        for (int i = 0; i < 3; i++) m_sum[i] += v[i];
        m_n++;
        if (m_n == NWIN) begin
            for (int i = 0; i < 3; i++) begin
                av[i] = m_sum[i] / NWIN;
                if (av[i] >= TH_HI) m_bit[i] = 1;
                else if (av[i] <= TH_LO) m_bit[i] = 0;
                m_sum[i] = 0;
            end
            m_n = 0;
            e.bits = m_bit[0] * 4 + m_bit[1] * 2 + m_bit[2];
            hist.push_back(e.bits);
            e.np = 0;
            if (mode == 0) begin
                if (run_len(7) == NC) begin mode = 1; e.np = 1; m_cnt = (m_cnt + 1) % 256; end
                else if (run_len(0) == NC) mode = 2;
            end else if (mode == 1) begin
                if (e.bits != 7) mode = 0;
            end else begin
                if (e.bits != 0) mode = 0;
            end
            e.a1 = av[0]; e.a2 = av[1]; e.a3 = av[2];
            e.cnt  = m_cnt;
            e.lost = (mode == 2) ? 1 : 0;
            e.cyc  = pcnt + SAMPLE_DIV;
            sb.push_back(e);
        end
        ch1 = 12'(a); ch2 = 12'(b); ch3 = 12'(c);
        repeat (SAMPLE_DIV) @(negedge sclk);
    endtask

    task automatic window(input int a, input int b, input int c);
        for (int s = 0; s < NWIN; s++) sample(a, b, c);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_avg_valid"}, AVG_VALID, 0);
        chk({tag, "_avg1"}, AVG_CH1, 0);
        chk({tag, "_avg2"}, AVG_CH2, 0);
        chk({tag, "_avg3"}, AVG_CH3, 0);
        chk({tag, "_line_bits"}, LINE_BITS, 0);
        chk({tag, "_node_pulse"}, NODE_PULSE, 0);
        chk({tag, "_node_count"}, NODE_COUNT, 0);
        chk({tag, "_line_lost"}, LINE_LOST, 0);
    endtask

    function automatic int clamp12(input int v);
        if (v < 0) return 0;
        if (v > 4095) return 4095;
        return v;
    endfunction

    // ---------------- monitor ----------------
    exp_t cur;
    bit   chk_next = 1'b0;

    always @(negedge sclk) begin
        if (rst) begin
            chk_next = 1'b0;
        end else begin
            if (chk_next) begin
                chk("node_pulse", NODE_PULSE, cur.np);
                chk("node_count", NODE_COUNT, cur.cnt);
                chk("line_lost", LINE_LOST, cur.lost);
                chk_next = 1'b0;
            end else begin
                chk("stray_node_pulse", NODE_PULSE, 0);
            end
            if (AVG_VALID) begin
                if (sb.size() == 0) begin
                    chk("unexpected_avg_valid", 1, 0);
                end else begin
                    cur = sb.pop_front();
                    chk("avg_ch1", AVG_CH1, cur.a1);
                    chk("avg_ch2", AVG_CH2, cur.a2);
                    chk("avg_ch3", AVG_CH3, cur.a3);
                    chk("line_bits", LINE_BITS, cur.bits);
                    chk("avg_valid_cycle", pcnt, cur.cyc);
                    chk_next = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int lv[6];
        int base[3];
        int reps, same, noisy;
        lv[0] = 100; lv[1] = 1600; lv[2] = 1601; lv[3] = 1999; lv[4] = 2000; lv[5] = 3000;

        model_reset();
        repeat (3) @(negedge sclk);
        check_reset("reset");
        rst = 1'b0;

        // All black from reset: node confirmed on the third average.
        for (int w = 0; w < 3; w++) window(3000, 3000, 3000);

        // All white for three averages -> lost; one channel back -> follow.
        for (int w = 0; w < 3; w++) window(100, 100, 100);
        window(100, 100, 3000);

        // Centre channel walks through the hysteresis band.
        window(3000, 1800, 3000);
        window(3000, 2100, 3000);
        window(3000, 1800, 3000);
        window(3000, 1500, 3000);

        // Alternating extremes: truncating average.
        for (int s = 0; s < NWIN; s++) sample((s % 2) ? 4095 : 0, 3000, 3000);

        // Long black stretch, a break, then a second node.
        for (int w = 0; w < 10; w++) window(3000, 3000, 3000);
        window(500, 3000, 3000);
        for (int w = 0; w < 3; w++) window(3000, 3000, 3000);

        // Reset in the middle of a block; pre-reset samples must be discarded.
        for (int s = 0; s < 7; s++) sample(4095, 4095, 4095);
        rst = 1'b1;
        model_reset();
        @(negedge sclk);
        check_reset("mid_reset");
        rst = 1'b0;
        window(1000, 1000, 1000);

        // Randomised segments around the thresholds.
        for (int seg = 0; seg < 14; seg++) begin
            reps  = $urandom_range(1, 4);
            same  = $urandom_range(0, 1);
            noisy = $urandom_range(0, 1);
            for (int i = 0; i < 3; i++) begin
                base[i] = lv[$urandom_range(0, 5)];
                if (same != 0) base[i] = base[0];
            end
            for (int w = 0; w < reps; w++) begin
                for (int s = 0; s < NWIN; s++) begin
                    int v[3];
                    for (int i = 0; i < 3; i++)
                        v[i] = clamp12(base[i] + ((noisy != 0) ? (int'($urandom_range(0, 200)) - 100) : 0));
                    sample(v[0], v[1], v[2]);
                end
            end
        end

        for (int k = 0; k < 40 && (sb.size() != 0 || chk_next); k++) @(negedge sclk);
        chk("drain_pending", sb.size() + int'(chk_next), 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
